// File: rtl/mux_pkg.sv
// Shared constants and types for the N:1 round-robin multiplexer family.
package mux_pkg;

  localparam int MUX_N_MAX = 16;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Index width for an n-channel mux; a lone channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority (lowest index) or round-robin
// starting one past the last winner held in ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  input  logic            rr_en,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any
);

  always_comb begin
    int start;
    int cand;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    start   = (rr_en == MODE_RR) ? ((int'(ptr) + 1) % N) : 0;
    // Walk the channels once from the start point, wrapping at N.
    for (int k = 0; k < N; k++) begin
      cand = (start + k) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDXW'(cand);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/muxn_rr.sv
// N:1 multiplexer with registered output, valid/ready on every port and
// selectable round-robin or fixed-priority arbitration.
module muxn_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N*WIDTH-1:0]       in_data,
  input  logic [N-1:0]             in_valid,
  output logic [N-1:0]             in_ready,
  input  logic                     rr_en,
  output logic [WIDTH-1:0]         out_data,
  output logic [idx_w(N)-1:0]      out_src,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int IDXW = idx_w(N);

  out_state_t      state;
  out_state_t      next_state;
  logic [IDXW-1:0] ptr;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            any;
  logic            take;
  logic            xfer;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(
    .N    (N),
    .IDXW (IDXW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .rr_en   (rr_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign take     = !out_valid || out_ready;
  assign xfer     = take && any;
  assign sel_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

  // Gate with rst_n: the slot looks free during reset, but nothing may be accepted.
  assign in_ready = (xfer && rst_n) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OUT_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (take) begin
      next_state = any ? OUT_FULL : OUT_EMPTY;
    end
  end

  always_comb begin
    out_valid = (state == OUT_FULL);
  end

  // Data and source only move on a transfer; draining to empty keeps them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= '0;
    end else if (xfer) begin
      out_data <= sel_data;
      out_src  <= gnt_idx;
    end
  end

  // Reset to N-1 so channel 0 is first in round-robin order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDXW'(N - 1);
    end else if (xfer && (rr_en == MODE_RR)) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_muxn_rr.sv
// Directed self-checking bench for muxn_rr with N=4, WIDTH=16.
module tb_muxn_rr;

  localparam int WIDTH = 16;
  localparam int N     = 4;

  logic             clk;
  logic             rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             rr_en;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_valid;
  logic             out_ready;

  int tests_run;
  int tests_failed;

  logic [WIDTH-1:0] chan_val [N];

  muxn_rr #(
    .WIDTH (WIDTH),
    .N     (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_en     (rr_en),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setData(input int ch, input logic [WIDTH-1:0] v);
    chan_val[ch] = v;
    in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic ready, input logic rr);
    in_valid  = valid;
    out_ready = ready;
    rr_en     = rr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    in_data      = '0;
    setData(0, 16'h1000);
    setData(1, 16'h1111);
    setData(2, 16'h2222);
    setData(3, 16'h3333);
    rst_n = 1'b0;
    applyStimulus(4'b1111, 1'b1, 1'b1);

    // Reset held with every channel requesting.
    tick();
    tick();
    #2;
    checkOutput("reset_in_ready", 32'(in_ready), 32'h0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_out_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;
    #1;

    // Round-robin sweep from reset: 0,1,2,3,0,1.
    for (int i = 0; i < 6; i++) begin
      checkOutput("rr_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
      tick();
      checkOutput("rr_out_src", 32'(out_src), 32'(i % 4));
      checkOutput("rr_out_data", 32'(out_data), 32'(chan_val[i % 4]));
      checkOutput("rr_out_valid", 32'(out_valid), 32'h1);
    end

    // Fixed priority: channels 1 and 3 request, 1 always wins.
    setData(1, 16'hA5A5);
    applyStimulus(4'b1010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("fp_in_ready", 32'(in_ready), 32'h2);
      tick();
      checkOutput("fp_out_src", 32'(out_src), 32'h1);
      checkOutput("fp_out_data", 32'(out_data), 32'hA5A5);
    end

    // Back-pressure: ptr is 1, so channel 2 loads 0x1234.
    setData(2, 16'h1234);
    applyStimulus(4'b0100, 1'b1, 1'b1);
    #1;
    checkOutput("bp_load_ready", 32'(in_ready), 32'h4);
    tick();
    checkOutput("bp_load_data", 32'(out_data), 32'h1234);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("bp_stall_ready", 32'(in_ready), 32'h0);
      tick();
      checkOutput("bp_hold_data", 32'(out_data), 32'h1234);
      checkOutput("bp_hold_valid", 32'(out_valid), 32'h1);
      checkOutput("bp_hold_src", 32'(out_src), 32'h2);
    end
    applyStimulus(4'b1111, 1'b1, 1'b1);
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'h8);
    tick();
    checkOutput("bp_release_src", 32'(out_src), 32'h3);
    checkOutput("bp_release_data", 32'(out_data), 32'h3333);

    // Drain: one word from channel 2, then nothing requests.
    applyStimulus(4'b0100, 1'b1, 1'b1);
    tick();
    checkOutput("drain_load_src", 32'(out_src), 32'h2);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    #1;
    checkOutput("drain_in_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("drain_out_valid", 32'(out_valid), 32'h0);
    checkOutput("drain_out_src", 32'(out_src), 32'h2);
    checkOutput("drain_out_data", 32'(out_data), 32'h1234);

    // Async reset while full and stalled; ptr is 2 so channel 1 loads.
    applyStimulus(4'b0010, 1'b1, 1'b1);
    tick();
    checkOutput("ar_load_src", 32'(out_src), 32'h1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("ar_stall_valid", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_out_valid", 32'(out_valid), 32'h0);
    checkOutput("ar_out_src", 32'(out_src), 32'h0);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    #1;
    checkOutput("ar_in_ready", 32'(in_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("ar_next_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("ar_next_src", 32'(out_src), 32'h0);
    checkOutput("ar_next_data", 32'(out_data), 32'h1000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
